// File: rtl/approx_mac_pkg.sv
// Shared types, default widths and helpers for the approximate MAC back end.
// Saturating accumulation is selected with the ACC_SAT_EN macro in approx_mac_accum.
package approx_mac_pkg;

  localparam int unsigned DefProdW  = 16;
  localparam int unsigned DefAccW   = 24;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefVecLen = 8;
  localparam int unsigned MaxAccW   = 64;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } mac_state_e;

  // All-ones value of an accumulator 'width' bits wide, right-aligned in MaxAccW bits.
  function automatic logic [MaxAccW-1:0] acc_sat_val(input int unsigned width);
    acc_sat_val = {MaxAccW{1'b1}} >> (MaxAccW - width);
  endfunction

endpackage

// File: rtl/approx_mac_out_slot.sv
// One-entry registered result slot with valid/ready handshake.
// A load in the same cycle as a pop refills the slot without a bubble.
module approx_mac_out_slot #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [ACC_W-1:0] data_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ovf_i,
  output logic             space_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [ACC_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic             valid_q, valid_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      count_d = count_i;
      ovf_d   = ovf_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign space_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/approx_mac_accum.sv
// Accumulates a stream of unsigned products into per-vector sums (MAC back end).
// Define ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module approx_mac_accum
  import approx_mac_pkg::*;
#(
  parameter int unsigned PROD_W  = DefProdW,
  parameter int unsigned ACC_W   = DefAccW,
  parameter int unsigned VEC_LEN = DefVecLen,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  input  logic [PROD_W-1:0] prod_data_i,
  input  logic              prod_last_i,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic [ACC_W-1:0]  acc_data_o,
  output logic [CNT_W-1:0]  acc_count_o,
  output logic              acc_ovf_o
);

  localparam logic             AutoTerm = (VEC_LEN != 0);
  localparam logic [CNT_W-1:0] LastCnt  = AutoTerm ? CNT_W'(VEC_LEN - 1) : '0;
  localparam logic [CNT_W-1:0] CntMax   = '1;
`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] AccSat   = ACC_W'(acc_sat_val(ACC_W));
`endif

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             beat, terminal, fresh, carry, load;
  logic [ACC_W-1:0] acc_base, acc_add;
  logic [CNT_W-1:0] cnt_base, cnt_add;
  logic             ovf_base, ovf_add;
  logic [ACC_W:0]   sum;

  always_comb begin
    beat  = prod_valid_i && prod_ready_o;
    // A vector always starts from zero, independent of any leftover register contents.
    fresh    = (state_q == StIdle);
    acc_base = fresh ? '0 : acc_q;
    cnt_base = fresh ? '0 : cnt_q;
    ovf_base = fresh ? 1'b0 : ovf_q;

    terminal = prod_last_i || (AutoTerm && (cnt_base == LastCnt));
    sum      = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data_i};
    carry    = sum[ACC_W];
`ifdef ACC_SAT_EN
    // Once clamped, every further add carries again, so the clamp holds for the vector.
    acc_add  = carry ? AccSat : sum[ACC_W-1:0];
`else
    acc_add  = sum[ACC_W-1:0];
`endif
    cnt_add  = (cnt_base == CntMax) ? CntMax : cnt_base + CNT_W'(1);
    ovf_add  = ovf_base | carry;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    if (clr_i) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (beat) begin
      if (terminal) begin
        load    = 1'b1;
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        state_d = StAccum;
        acc_d   = acc_add;
        cnt_d   = cnt_add;
        ovf_d   = ovf_add;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  approx_mac_out_slot #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_out_slot (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .data_i (acc_add),
    .count_i(cnt_add),
    .ovf_i  (ovf_add),
    .space_o(prod_ready_o),
    .valid_o(acc_valid_o),
    .ready_i(acc_ready_i),
    .data_o (acc_data_o),
    .count_o(acc_count_o),
    .ovf_o  (acc_ovf_o)
  );

endmodule

// File: tb/tb_approx_mac_accum.sv
// Bench for approx_mac_accum: three configurations, directed tables, corner sequences and a
// randomized run scored against a per-vector arithmetic model.
module tb_approx_mac_accum;

  localparam int NI = 3;
  localparam int VL [NI] = '{8, 3, 0};
  localparam int AW [NI] = '{24, 16, 24};
  localparam int CW [NI] = '{8, 8, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr        [NI];
  logic        prod_valid [NI];
  logic [15:0] prod_data  [NI];
  logic        prod_last  [NI];
  logic        acc_ready  [NI];

  logic        pr0, pr1, pr2, av0, av1, av2, o0, o1, o2;
  logic [23:0] d0, d2;
  logic [15:0] d1;
  logic [7:0]  c0, c1;
  logic [2:0]  c2;

  logic        prod_ready_w [NI];
  logic        acc_valid_w  [NI];
  logic [23:0] acc_data_w   [NI];
  logic [7:0]  acc_count_w  [NI];
  logic        acc_ovf_w    [NI];

  approx_mac_accum #(.PROD_W(16), .ACC_W(24), .VEC_LEN(8), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .prod_valid_i(prod_valid[0]),
    .prod_ready_o(pr0), .prod_data_i(prod_data[0]), .prod_last_i(prod_last[0]),
    .acc_valid_o(av0), .acc_ready_i(acc_ready[0]), .acc_data_o(d0), .acc_count_o(c0),
    .acc_ovf_o(o0)
  );
  approx_mac_accum #(.PROD_W(16), .ACC_W(16), .VEC_LEN(3), .CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .prod_valid_i(prod_valid[1]),
    .prod_ready_o(pr1), .prod_data_i(prod_data[1]), .prod_last_i(prod_last[1]),
    .acc_valid_o(av1), .acc_ready_i(acc_ready[1]), .acc_data_o(d1), .acc_count_o(c1),
    .acc_ovf_o(o1)
  );
  approx_mac_accum #(.PROD_W(16), .ACC_W(24), .VEC_LEN(0), .CNT_W(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[2]), .prod_valid_i(prod_valid[2]),
    .prod_ready_o(pr2), .prod_data_i(prod_data[2]), .prod_last_i(prod_last[2]),
    .acc_valid_o(av2), .acc_ready_i(acc_ready[2]), .acc_data_o(d2), .acc_count_o(c2),
    .acc_ovf_o(o2)
  );

  always_comb begin
    prod_ready_w[0] = pr0; prod_ready_w[1] = pr1; prod_ready_w[2] = pr2;
    acc_valid_w[0]  = av0; acc_valid_w[1]  = av1; acc_valid_w[2]  = av2;
    acc_data_w[0]   = d0;  acc_data_w[1]   = {8'h00, d1}; acc_data_w[2] = d2;
    acc_count_w[0]  = c0;  acc_count_w[1]  = c1;  acc_count_w[2]  = {5'h00, c2};
    acc_ovf_w[0]    = o0;  acc_ovf_w[1]    = o1;  acc_ovf_w[2]    = o2;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int k, input longint got, input longint want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s[dut%0d] at %0t: got 0x%0h, want 0x%0h", nm, k, $time, got, want);
  endtask

  // Scoreboard: one pending result per instance, built from the raw beat sums.
  bit     pend_v    [NI];
  longint pend_data [NI];
  longint pend_cnt  [NI];
  bit     pend_ovf  [NI];
  longint tot       [NI];
  longint nb        [NI];
  bit     exp_rdy;
  longint lim;

  initial begin
    for (int k = 0; k < NI; k++) begin
      pend_v[k] = 0; tot[k] = 0; nb[k] = 0;
      pend_data[k] = 0; pend_cnt[k] = 0; pend_ovf[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        chk("rst_acc_valid", k, acc_valid_w[k], 0);
        chk("rst_acc_data", k, acc_data_w[k], 0);
        chk("rst_acc_count", k, acc_count_w[k], 0);
        chk("rst_acc_ovf", k, acc_ovf_w[k], 0);
        chk("rst_prod_ready", k, prod_ready_w[k], 1);
        pend_v[k] = 0; tot[k] = 0; nb[k] = 0;
      end else begin
        chk("sb_acc_valid", k, acc_valid_w[k], pend_v[k]);
        if (pend_v[k]) begin
          chk("sb_acc_data", k, acc_data_w[k], pend_data[k]);
          chk("sb_acc_count", k, acc_count_w[k], pend_cnt[k]);
          chk("sb_acc_ovf", k, acc_ovf_w[k], pend_ovf[k]);
        end
        exp_rdy = !pend_v[k] || acc_ready[k];
        chk("sb_prod_ready", k, prod_ready_w[k], exp_rdy);
        if (pend_v[k] && acc_ready[k]) pend_v[k] = 0;
        if (clr[k]) begin
          tot[k] = 0; nb[k] = 0;
        end else if (prod_valid[k] && exp_rdy) begin
          tot[k] += prod_data[k];
          nb[k]++;
          if (prod_last[k] || (VL[k] != 0 && nb[k] == VL[k])) begin
            lim = longint'(1) << AW[k];
            pend_ovf[k] = (tot[k] >= lim);
`ifdef ACC_SAT_EN
            pend_data[k] = pend_ovf[k] ? lim - 1 : tot[k];
`else
            pend_data[k] = tot[k] % lim;
`endif
            pend_cnt[k] = (nb[k] > (longint'(1) << CW[k]) - 1) ? (longint'(1) << CW[k]) - 1
                                                                 : nb[k];
            pend_v[k] = 1; tot[k] = 0; nb[k] = 0;
          end
        end
      end
    end
  end

  typedef struct {
    int          k;
    int          n;
    logic [15:0] vf;
    logic [15:0] vr;
    bit          use_last;
    longint      exp_data;
    longint      exp_cnt;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl [9];

  // Presents one beat (call just after a rising edge); returns just after the accepting edge.
  task automatic drive_beat(input int k, input logic [15:0] d, input logic last);
    int w;
    prod_valid[k] = 1'b1; prod_data[k] = d; prod_last[k] = last;
    w = 0;
    @(negedge clk);
    while (!prod_ready_w[k] && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) chk("beat_ready_timeout", k, 0, 1);
    @(posedge clk); #1;
    prod_valid[k] = 1'b0; prod_last[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      clr[k] = 0; prod_valid[k] = 0; prod_data[k] = 0; prod_last[k] = 0; acc_ready[k] = 1;
    end
    tbl[0] = '{0, 4, 16'h0100, 16'h0100, 1, 24'h000400, 4, 0};
    tbl[1] = '{0, 1, 16'h0007, 16'h0007, 1, 24'h000007, 1, 0};
    tbl[2] = '{0, 8, 16'hFFFF, 16'hFFFF, 0, 24'h07FFF8, 8, 0};
    tbl[3] = '{0, 3, 16'h1234, 16'h1234, 1, 24'h00369C, 3, 0};
`ifdef ACC_SAT_EN
    tbl[4] = '{1, 2, 16'hFFFF, 16'h0002, 1, 16'hFFFF, 2, 1};
`else
    tbl[4] = '{1, 2, 16'hFFFF, 16'h0002, 1, 16'h0001, 2, 1};
`endif
    tbl[5] = '{1, 1, 16'h0005, 16'h0005, 1, 16'h0005, 1, 0};
    tbl[6] = '{1, 3, 16'h0001, 16'h0001, 0, 16'h0003, 3, 0};
    tbl[7] = '{2, 10, 16'h0002, 16'h0002, 1, 24'h000014, 7, 0};
    tbl[8] = '{2, 9, 16'h8000, 16'h8000, 1, 24'h048000, 7, 0};

    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      for (int b = 0; b < tbl[i].n; b++) begin
        drive_beat(tbl[i].k, (b == 0) ? tbl[i].vf : tbl[i].vr,
                   tbl[i].use_last && (b == tbl[i].n - 1));
      end
      @(negedge clk);
      chk("tbl_acc_valid", tbl[i].k, acc_valid_w[tbl[i].k], 1);
      chk("tbl_acc_data", tbl[i].k, acc_data_w[tbl[i].k], tbl[i].exp_data);
      chk("tbl_acc_count", tbl[i].k, acc_count_w[tbl[i].k], tbl[i].exp_cnt);
      chk("tbl_acc_ovf", tbl[i].k, acc_ovf_w[tbl[i].k], tbl[i].exp_ovf);
      @(posedge clk); #1;
    end

    // Auto-terminated vectors of 3 back to back: no stall between them.
    for (int i = 0; i < 6; i++) begin
      prod_valid[1] = 1; prod_data[1] = 16'h0001; prod_last[1] = 0;
      @(negedge clk);
      chk("b2b_prod_ready", 1, prod_ready_w[1], 1);
      if (i == 3) begin
        chk("b2b_first_valid", 1, acc_valid_w[1], 1);
        chk("b2b_first_data", 1, acc_data_w[1], 3);
        chk("b2b_first_count", 1, acc_count_w[1], 3);
      end
      @(posedge clk); #1;
    end
    prod_valid[1] = 0;
    @(negedge clk);
    chk("b2b_second_valid", 1, acc_valid_w[1], 1);
    chk("b2b_second_data", 1, acc_data_w[1], 3);
    @(posedge clk); #1;

    // Backpressure: result held stable, input stalled, then pop plus reload in one edge.
    acc_ready[0] = 0;
    drive_beat(0, 16'h0010, 0);
    drive_beat(0, 16'h0020, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_acc_valid", 0, acc_valid_w[0], 1);
      chk("bp_prod_ready", 0, prod_ready_w[0], 0);
      chk("bp_acc_data", 0, acc_data_w[0], 24'h000030);
    end
    @(posedge clk); #1;
    acc_ready[0] = 1; prod_valid[0] = 1; prod_data[0] = 16'h0009; prod_last[0] = 1;
    @(negedge clk);
    chk("pop_prod_ready", 0, prod_ready_w[0], 1);
    chk("pop_acc_data", 0, acc_data_w[0], 24'h000030);
    @(posedge clk); #1;
    prod_valid[0] = 0; prod_last[0] = 0;
    @(negedge clk);
    chk("reload_acc_valid", 0, acc_valid_w[0], 1);
    chk("reload_acc_data", 0, acc_data_w[0], 24'h000009);
    chk("reload_acc_count", 0, acc_count_w[0], 1);
    @(posedge clk); #1;

    // Abort mid-vector; the beat offered with clr is dropped.
    drive_beat(0, 16'h0010, 0);
    drive_beat(0, 16'h0010, 0);
    clr[0] = 1; prod_valid[0] = 1; prod_data[0] = 16'h0100; prod_last[0] = 0;
    @(posedge clk); #1;
    clr[0] = 0; prod_valid[0] = 0;
    drive_beat(0, 16'h0005, 1);
    @(negedge clk);
    chk("clr_acc_valid", 0, acc_valid_w[0], 1);
    chk("clr_acc_data", 0, acc_data_w[0], 24'h000005);
    chk("clr_acc_count", 0, acc_count_w[0], 1);
    chk("clr_acc_ovf", 0, acc_ovf_w[0], 0);
    @(posedge clk); #1;

    // Reset with a held result and a partial vector in flight.
    acc_ready[0] = 0;
    drive_beat(0, 16'h0011, 1);
    drive_beat(2, 16'h0003, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_acc_valid", 0, acc_valid_w[0], 0);
    chk("async_rst_acc_data", 0, acc_data_w[0], 0);
    chk("async_rst_prod_ready", 0, prod_ready_w[0], 1);
    @(negedge clk); #2 rst_n = 1'b1;
    acc_ready[0] = 1;
    @(posedge clk); #1;
    drive_beat(0, 16'h0007, 1);
    @(negedge clk);
    chk("post_rst_acc_data", 0, acc_data_w[0], 24'h000007);
    chk("post_rst_acc_count", 0, acc_count_w[0], 1);
    @(posedge clk); #1;
    drive_beat(2, 16'h0004, 1);
    @(negedge clk);
    chk("post_rst_partial_lost", 2, acc_data_w[2], 24'h000004);
    @(posedge clk); #1;

    // Randomized traffic checked by the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        prod_valid[k] = ($urandom_range(0, 2) != 0);
        prod_data[k]  = 16'($urandom_range(0, 16'hFFFF));
        prod_last[k]  = (k == 2) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 4) == 0);
        acc_ready[k]  = ($urandom_range(0, 3) != 0);
        clr[k]        = ($urandom_range(0, 39) == 0);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < NI; k++) begin
      prod_valid[k] = 0; prod_last[k] = 0; clr[k] = 0; acc_ready[k] = 1;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
